// File: rtl/mips_pkg.sv
// Shared definitions for the MEM stage: access FSM states, timeout default,
// word-alignment helper and the packed MEM/WB payload.
package mips_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } mem_state_e;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 64;
  localparam logic [1:0]  WORD_ALIGN_MASK        = 2'b11;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic [31:0] pc_next;
    logic        misalign;
    logic        bus_err;
  } wb_t;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] & WORD_ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and memory (slave).
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/reg_mem2wb.sv
// MEM/WB pipeline register: loads a full payload on completion, otherwise
// inserts a bubble that keeps the data fields but kills valid, write and flags.
module reg_mem2wb
  import mips_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  wb_t  wb_d_i,
  output wb_t  wb_o
);

  wb_t wb_q;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  // NOTE: every WB register is reset; none of this is memory, so nothing is left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q <= '0;
    end else if (load_i) begin
      wb_q <= wb_d_i;
    end else begin
      wb_q.valid     <= 1'b0;
      wb_q.reg_write <= 1'b0;
      wb_q.misalign  <= 1'b0;
      wb_q.bus_err   <= 1'b0;
    end
  end

  assign wb_o = wb_q;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues one data-memory access per load/store, stalls the
// front of the pipe until ack or timeout, and feeds the MEM/WB register.
module mem_stage
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_MEM,
  input  logic [31:0] PC_next_MEM,
  input  logic        MemtoReg_MEM,
  input  logic        MemWrite_MEM,
  input  logic        RegWrite_MEM,
  input  logic [4:0]  writeAddr_MEM,
  input  logic [31:0] ALU_result_MEM,
  input  logic [31:0] storeData_MEM,
  mem_stage_if.master dmem,
  output logic        stall_MEM,
  output logic        valid_WB,
  output logic        RegWrite_WB,
  output logic [4:0]  writeAddr_WB,
  output logic [31:0] writeData_WB,
  output logic [31:0] PC_next_WB,
  output logic        misalign_WB,
  output logic        bus_err_WB
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mem_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              req_q;
  logic              we_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;

  logic mem_op;
  logic aligned;
  logic start;
  logic ack_done;
  logic timeout;
  logic misalign;
  logic wb_load;
  wb_t  wb_d;
  wb_t  wb_q;

  assign mem_op  = valid_MEM && (MemtoReg_MEM || MemWrite_MEM);
  assign aligned = is_word_aligned(ALU_result_MEM);

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    start    = 1'b0;
    ack_done = 1'b0;
    timeout  = 1'b0;
    misalign = 1'b0;
    case (state_q)
      IDLE: begin
        start    = mem_op && aligned;
        misalign = mem_op && !aligned;
      end
      REQ: begin
        ack_done = dmem.dmem_ack;
        timeout  = !dmem.dmem_ack && (cnt_q == CNT_LAST);
      end
    endcase
  end

  // Ack beats timeout in the last REQ cycle; either one ends the stall.
  assign stall_MEM = start || ((state_q == REQ) && !ack_done && !timeout);
  assign wb_load   = valid_MEM && !stall_MEM;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= REQ;
            cnt_q   <= '0;
            req_q   <= 1'b1;
            we_q    <= MemWrite_MEM;
            addr_q  <= ALU_result_MEM;
            wdata_q <= storeData_MEM;
          end
        end
        REQ: begin
          if (ack_done || timeout) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;

  // Faulting ops complete but must not write the register file.
  always_comb begin
    wb_d            = '0;
    wb_d.valid      = 1'b1;
    wb_d.reg_write  = RegWrite_MEM && !misalign && !timeout;
    wb_d.write_addr = writeAddr_MEM;
    wb_d.write_data = (MemtoReg_MEM && ack_done) ? dmem.dmem_rdata : ALU_result_MEM;
    wb_d.pc_next    = PC_next_MEM;
    wb_d.misalign   = misalign;
    wb_d.bus_err    = timeout;
  end

  reg_mem2wb u_reg_mem2wb (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (wb_load),
    .wb_d_i (wb_d),
    .wb_o   (wb_q)
  );

  assign valid_WB     = wb_q.valid;
  assign RegWrite_WB  = wb_q.reg_write;
  assign writeAddr_WB = wb_q.write_addr;
  assign writeData_WB = wb_q.write_data;
  assign PC_next_WB   = wb_q.pc_next;
  assign misalign_WB  = wb_q.misalign;
  assign bus_err_WB   = wb_q.bus_err;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a driver models the pipeline and pushes expected
// WB results and memory accesses; a memory responder and a WB monitor check them.
module tb_mem_stage;

  localparam int TO = 4;

  typedef struct {
    logic        rw;
    logic [4:0]  wa;
    logic [31:0] data;
    logic [31:0] pc;
    logic        mis;
    logic        berr;
    bit          chk_data;
  } wb_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
    int          req_len;
  } acc_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_MEM;
  logic [31:0] PC_next_MEM;
  logic        MemtoReg_MEM;
  logic        MemWrite_MEM;
  logic        RegWrite_MEM;
  logic [4:0]  writeAddr_MEM;
  logic [31:0] ALU_result_MEM;
  logic [31:0] storeData_MEM;
  logic        stall_MEM;
  logic        valid_WB;
  logic        RegWrite_WB;
  logic [4:0]  writeAddr_WB;
  logic [31:0] writeData_WB;
  logic [31:0] PC_next_WB;
  logic        misalign_WB;
  logic        bus_err_WB;

  mem_stage_if dmem_bus ();

  int      checks = 0;
  int      errors = 0;
  wb_exp_t wb_q[$];
  acc_t    resp_q[$];
  bit      resp_en = 1'b1;
  logic    force_ack = 1'b0;

  mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_MEM      (valid_MEM),
    .PC_next_MEM    (PC_next_MEM),
    .MemtoReg_MEM   (MemtoReg_MEM),
    .MemWrite_MEM   (MemWrite_MEM),
    .RegWrite_MEM   (RegWrite_MEM),
    .writeAddr_MEM  (writeAddr_MEM),
    .ALU_result_MEM (ALU_result_MEM),
    .storeData_MEM  (storeData_MEM),
    .dmem           (dmem_bus),
    .stall_MEM      (stall_MEM),
    .valid_WB       (valid_WB),
    .RegWrite_WB    (RegWrite_WB),
    .writeAddr_WB   (writeAddr_WB),
    .writeData_WB   (writeData_WB),
    .PC_next_WB     (PC_next_WB),
    .misalign_WB    (misalign_WB),
    .bus_err_WB     (bus_err_WB)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: decides the WB result, stall length and memory access from
  // the instruction and the chosen memory latency, then drives the instruction
  // and holds it while the stage stalls.
  task automatic issue(input logic v, input logic ld, input logic st, input logic rw,
                       input logic [4:0] wa, input logic [31:0] alu, input logic [31:0] sd,
                       input logic [31:0] pc, input int lat, input logic [31:0] rd);
    wb_exp_t e;
    acc_t    a;
    int      exp_stall;
    int      n;
    bit      mem_op;
    bit      timed_out;
    mem_op    = v && (ld || st);
    exp_stall = 0;
    if (v) begin
      e = '{rw: rw, wa: wa, data: alu, pc: pc, mis: 1'b0, berr: 1'b0, chk_data: 1'b1};
      if (mem_op && (alu % 4 != 0)) begin
        e.mis = 1'b1; e.rw = 1'b0; e.chk_data = 1'b0;
      end else if (mem_op) begin
        timed_out = (lat >= TO);
        exp_stall = timed_out ? TO : lat + 1;
        a = '{we: st, addr: alu, wdata: sd, rdata: rd, lat: lat, req_len: exp_stall};
        resp_q.push_back(a);
        if (timed_out) begin
          e.berr = 1'b1; e.rw = 1'b0; e.chk_data = 1'b0;
        end else if (ld) begin
          e.data = rd;
        end
      end
      wb_q.push_back(e);
    end
    @(negedge clk);
    valid_MEM = v; MemtoReg_MEM = ld; MemWrite_MEM = st; RegWrite_MEM = rw;
    writeAddr_MEM = wa; ALU_result_MEM = alu; storeData_MEM = sd; PC_next_MEM = pc;
    n = 0;
    #1;
    while (stall_MEM && n <= TO + 2) begin
      n++;
      @(negedge clk);
      #1;
    end
    check("stall_cycles", n, exp_stall);
  endtask

  // Memory responder: acks each access after its chosen latency, checks the request.
  initial begin
    acc_t r;
    bit   active;
    int   cnt;
    active = 1'b0;
    cnt    = 0;
    r      = '{we: 1'b0, addr: '0, wdata: '0, rdata: '0, lat: 0, req_len: 0};
    dmem_bus.dmem_ack   = 1'b0;
    dmem_bus.dmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!resp_en) begin
        active = 1'b0;
        dmem_bus.dmem_ack   = force_ack;
        dmem_bus.dmem_rdata = $urandom;
      end else if (!dmem_bus.dmem_req) begin
        if (active) check("req_len", cnt, r.req_len);
        active = 1'b0;
        dmem_bus.dmem_ack   = 1'($urandom);
        dmem_bus.dmem_rdata = $urandom;
      end else begin
        if (!active) begin
          if (resp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_req: got addr %h expected no request", dmem_bus.dmem_addr);
            r = '{we: 1'b0, addr: dmem_bus.dmem_addr, wdata: '0, rdata: '0, lat: 1000, req_len: 0};
          end else begin
            r = resp_q.pop_front();
            check("req_we", dmem_bus.dmem_we, r.we);
            check("req_wdata", dmem_bus.dmem_wdata, r.wdata);
          end
          active = 1'b1;
          cnt    = 0;
        end
        check("req_addr", dmem_bus.dmem_addr, r.addr);
        dmem_bus.dmem_ack   = (cnt == r.lat);
        dmem_bus.dmem_rdata = (cnt == r.lat) ? r.rdata : $urandom;
        cnt++;
      end
    end
  end

  // WB monitor: every valid WB entry is matched against the scoreboard queue.
  initial begin
    wb_exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (valid_WB) begin
          if (wb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_wb: got pc %h expected no valid WB", PC_next_WB);
          end else begin
            e = wb_q.pop_front();
            check("wb_regwrite", RegWrite_WB, e.rw);
            check("wb_addr", writeAddr_WB, e.wa);
            check("wb_pc", PC_next_WB, e.pc);
            check("wb_misalign", misalign_WB, e.mis);
            check("wb_bus_err", bus_err_WB, e.berr);
            if (e.chk_data) check("wb_data", writeData_WB, e.data);
          end
        end else begin
          check("bubble_flags", {RegWrite_WB, misalign_WB, bus_err_WB}, 3'b000);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    valid_MEM = 1'b0; MemtoReg_MEM = 1'b0; MemWrite_MEM = 1'b0; RegWrite_MEM = 1'b0;
    writeAddr_MEM = '0; ALU_result_MEM = '0; storeData_MEM = '0; PC_next_MEM = '0;
    #12;
    check("rst_req", dmem_bus.dmem_req, 1'b0);
    check("rst_we", dmem_bus.dmem_we, 1'b0);
    check("rst_addr", dmem_bus.dmem_addr, 32'h0);
    check("rst_wdata", dmem_bus.dmem_wdata, 32'h0);
    check("rst_wb", {valid_WB, RegWrite_WB, misalign_WB, bus_err_WB}, 4'h0);
    check("rst_wb_data", writeData_WB, 32'h0);
    check("rst_wb_pc", PC_next_WB, 32'h0);
    check("rst_wb_addr", writeAddr_WB, 32'h0);
    check("rst_stall", stall_MEM, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(1, 0, 0, 1, 5'd3, 32'h1234_5678, 32'h0, 32'h0000_0104, 0, 32'h0);
    issue(1, 1, 0, 1, 5'd5, 32'h0000_0010, 32'h0, 32'h0000_0108, 2, 32'hABC1_2345);
    issue(1, 0, 1, 0, 5'd0, 32'h0000_0020, 32'h3066_3220, 32'h0000_010C, 0, 32'h0);
    issue(1, 1, 0, 1, 5'd7, 32'h0000_0013, 32'h0, 32'h0000_0110, 0, 32'h0);
    issue(1, 1, 0, 1, 5'd8, 32'h0000_0030, 32'h0, 32'h0000_0114, TO + 1, 32'h0);
    issue(1, 1, 0, 1, 5'd9, 32'h0000_0034, 32'h0, 32'h0000_0118, TO - 1, 32'h5A5A_0001);
    issue(0, 1, 0, 1, 5'd10, 32'h0000_0038, 32'h0, 32'h0000_011C, 0, 32'h0);
    issue(1, 0, 1, 1, 5'd11, 32'h0000_0041, 32'hDEAD_BEEF, 32'h0000_0120, 0, 32'h0);

    for (int i = 0; i < 300; i++) begin
      logic        v;
      logic [31:0] alu;
      int          kind;
      v    = ($urandom_range(0, 7) != 0);
      kind = $urandom_range(0, 2);
      alu  = $urandom;
      if ($urandom_range(0, 4) != 0) alu[1:0] = 2'b00;
      issue(v, kind == 1, kind == 2, 1'($urandom), 5'($urandom), alu, $urandom, $urandom,
            $urandom_range(0, TO + 1), $urandom);
    end

    @(negedge clk);
    valid_MEM = 1'b0;
    repeat (3) @(negedge clk);
    check("wb_queue_drained", wb_q.size(), 0);
    check("req_queue_drained", resp_q.size(), 0);

    // Reset in the middle of an access, then a late ack must be ignored.
    resp_en   = 1'b0;
    force_ack = 1'b0;
    @(negedge clk);
    valid_MEM = 1'b1; MemtoReg_MEM = 1'b1; MemWrite_MEM = 1'b0; RegWrite_MEM = 1'b1;
    writeAddr_MEM = 5'd9; ALU_result_MEM = 32'h0000_0040; PC_next_MEM = 32'h0000_0200;
    @(negedge clk);
    #1;
    check("mid_req_active", dmem_bus.dmem_req, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_req_drop", dmem_bus.dmem_req, 1'b0);
    check("async_wb_clear", {valid_WB, RegWrite_WB, misalign_WB, bus_err_WB}, 4'h0);
    check("async_wb_data", writeData_WB, 32'h0);
    valid_MEM = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    force_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      check("late_ack_req", dmem_bus.dmem_req, 1'b0);
      check("late_ack_wb", {valid_WB, RegWrite_WB, misalign_WB, bus_err_WB}, 4'h0);
      check("late_ack_addr", writeAddr_WB, 32'h0);
      check("late_ack_data", writeData_WB, 32'h0);
      check("late_ack_pc", PC_next_WB, 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: maximum cycles dmem_req stays high without dmem_ack before the access is aborted.
REQ-002 clk  in  1  single rising-edge clock.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 valid_MEM  in  1  the MEM-stage instruction is valid.
REQ-005 PC_next_MEM  in  32  PC+4 of the MEM-stage instruction.
REQ-006 MemtoReg_MEM  in  1  instruction is a load.
REQ-007 MemWrite_MEM  in  1  instruction is a store.
REQ-008 RegWrite_MEM  in  1  instruction writes the register file.
REQ-009 writeAddr_MEM  in  5  destination register.
REQ-010 ALU_result_MEM  in  32  ALU result, used as the memory address for loads and stores.
REQ-011 storeData_MEM  in  32  store data.
REQ-012 dmem_req / dmem_we  out  1 / 1  memory request and write enable.
REQ-013 dmem_addr / dmem_wdata  out  32 / 32  memory address and write data.
REQ-014 dmem_ack / dmem_rdata  in  1 / 32  memory completion and read data.
REQ-015 stall_MEM  out  1  freezes Reg_EX2MEM and every earlier stage.
REQ-016 valid_WB, RegWrite_WB  out  1 each  registered WB controls.
REQ-017 writeAddr_WB  out  5  registered destination register.
REQ-018 writeData_WB / PC_next_WB  out  32 each  registered write-back data and PC+4.
REQ-019 misalign_WB, bus_err_WB  out  1 each  registered exception flags.

Function
REQ-020 Memory op: valid_MEM=1 and (MemtoReg_MEM=1 or MemWrite_MEM=1).
REQ-021 FSM states are IDLE and REQ.
- IDLE to REQ: memory op with ALU_result_MEM[1:0]=0.
- REQ to IDLE: dmem_ack=1, or timeout.
REQ-022 On the IDLE-to-REQ edge, the block registers dmem_req=1, dmem_we=MemWrite_MEM, dmem_addr=ALU_result_MEM and dmem_wdata=storeData_MEM; these outputs hold constant through REQ.
REQ-023 stall_MEM is combinational. It is 1 in the IDLE cycle that starts an access and in every REQ cycle with dmem_ack=0; it is 0 in the ack cycle.
REQ-024 Minimum memory-op occupancy is 2 cycles (ack in the first REQ cycle).
REQ-025 Non-memory ops complete in 1 cycle with no stall.
REQ-026 Completion edge: WB registers capture valid_WB=valid_MEM, RegWrite_WB=RegWrite_MEM, writeAddr_WB, PC_next_WB.
- writeData_WB = dmem_rdata for loads, ALU_result_MEM otherwise.
- In the same edge, dmem_req goes to 0.
REQ-027 In each stalled cycle, WB captures a bubble: valid_WB=0, RegWrite_WB=0, both flags 0.
REQ-028 Misaligned memory op (address[1:0]≠0): no request is issued; completes in 1 cycle with misalign_WB=1 and RegWrite_WB=0.
REQ-029 Timeout: the counter clears on REQ entry and increments each REQ cycle without ack.
- At count TIMEOUT_CYCLES-1 with no ack: dmem_req drops, the op completes with bus_err_WB=1 and RegWrite_WB=0, and stall_MEM=0 in that cycle.
REQ-030 An ack arriving in the timeout cycle wins: normal completion, bus_err_WB=0.
REQ-031 dmem_ack while IDLE is ignored.
REQ-032 valid_MEM=0 produces a bubble regardless of the other inputs.

Reset
REQ-033 While rst_n=0: FSM=IDLE, counter=0, and every output register is 0 (dmem_*, all *_WB).
REQ-034 Reset during REQ drops dmem_req asynchronously and abandons the access; an ack arriving after reset release is ignored (REQ-031).

Structure
REQ-035 Shared package mips_pkg holds the state enumeration, the default TIMEOUT_CYCLES and the word-alignment mask constant.
REQ-036 The WB output registers form one sub-module, reg_mem2wb, with a load/bubble select; the FSM, counter and stall logic stay in mem_stage.

Verification
REQ-037 ALU-only op: ALU_result_MEM=0x12345678, RegWrite_MEM=1, writeAddr_MEM=3 -> next edge writeData_WB=0x12345678, writeAddr_WB=3, no stall.
REQ-038 Load at 0x00000010, ack after 3 REQ cycles with rdata=0xABC12345 -> stall_MEM high for 3 cycles, 3 bubbles, then writeData_WB=0xABC12345.
REQ-039 Store at 0x00000020 with data 0x30663220, immediate ack -> dmem_we=1, dmem_wdata=0x30663220 for one cycle, RegWrite_WB=0.
REQ-040 Load at 0x00000013 -> dmem_req stays 0, misalign_WB=1 after 1 cycle.
REQ-041 TIMEOUT_CYCLES=4, no ack -> dmem_req high 4 cycles, then bus_err_WB=1.
REQ-042 Assert rst_n=0 mid-REQ -> dmem_req drops immediately; a late ack is ignored and all *_WB outputs stay 0.
